// File: rtl/temporal_encoder_16.sv
`timescale 1ns/1ps
// temporal_encoder_16
// Time-to-first-spike encoder for 16 lines. An accepted vector of T_W-bit
// values opens a window of 2^T_W cycles; line i falls (1->0) in the window
// cycle equal to its value and stays low until a one-cycle gap restores all
// lines high. The all-ones value means "no spike" for that line.
// Every output comes straight from a flop. The next output values are
// computed from the next state, so each output flop already holds the value
// for the state that is entered on the same edge.
module temporal_encoder_16 #(
  parameter int T_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [16*T_W-1:0] in_values,
  output logic [15:0]      spike_out,
  output logic             busy,
  output logic             window_done
);

  localparam logic [T_W-1:0] MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [T_W-1:0]      cnt_reg, cnt_next;
  logic [16*T_W-1:0]   vals_reg, vals_next;
  logic [15:0]         spike_reg, spike_next;
  logic                ready_reg, ready_next;
  logic                busy_reg, busy_next;
  logic                done_reg, done_next;
  logic                accept;

  // A vector is taken only while the ready flop is high; at all other times
  // the inputs are ignored.
  assign accept = in_valid & ready_reg;

  // Next-state and window counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    vals_next  = vals_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          vals_next  = in_values;
          cnt_next   = '0;
          state_next = FIRE;
        end
      end
      FIRE: begin
        // The counter holds at MAX on the last cycle; the window never wraps.
        if (cnt_reg == MAX) begin
          state_next = GAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake/status values for the state being entered.
  always_comb begin
    ready_next = (state_next == IDLE);
    busy_next  = (state_next != IDLE);
    done_next  = (state_next == FIRE) && (cnt_next == MAX);
  end

  // One comparator per line: the line is low once the window count has
  // reached its value, so equal values fall together in the same cycle.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_line
      logic [T_W-1:0] line_val;
      assign line_val       = vals_next[gi*T_W +: T_W];
      assign spike_next[gi] = !((state_next == FIRE) &&
                                (line_val <= cnt_next) &&
                                (line_val != MAX));
    end
  endgenerate

  // State, counter, latched values and output flops; reset aborts any window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      vals_reg  <= '1;
      spike_reg <= 16'hFFFF;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      vals_reg  <= vals_next;
      spike_reg <= spike_next;
      ready_reg <= ready_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign spike_out   = spike_reg;
  assign in_ready    = ready_reg;
  assign busy        = busy_reg;
  assign window_done = done_reg;

endmodule

// File: tb/tb_temporal_encoder_16.sv
`timescale 1ns/1ps
// Directed testbench for temporal_encoder_16 (T_W = 3).
module tb_temporal_encoder_16;

  localparam int T_W = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [16*T_W-1:0] in_values;
  logic [15:0]       spike_out;
  logic              busy;
  logic              window_done;

  int errors = 0;
  int checks = 0;

  int fall_cyc [16];
  int fallen_q [$];

  temporal_encoder_16 #(.T_W(T_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_values   (in_values),
    .spike_out   (spike_out),
    .busy        (busy),
    .window_done (window_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish before 200000ns");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Expected lines for window cycle c: low iff value <= c and value != 7.
  function automatic logic [15:0] exp_spike(input logic [47:0] vals, input int c);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) begin
      int v;
      v = int'(vals[i*3 +: 3]);
      r[i] = !((v <= c) && (v != 7));
    end
    return r;
  endfunction

  // Accept a vector from IDLE and check the full window, gap and return to idle.
  task automatic run_window(input string tag, input logic [47:0] vals);
    logic [15:0] prev;
    check($sformatf("%s idle_ready", tag), 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_values = vals;
    @(posedge clk);
    #1 in_valid = 1'b0;
    prev = 16'hFFFF;
    fallen_q.delete();
    for (int i = 0; i < 16; i++) fall_cyc[i] = 8;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("%s c%0d spike", tag, c), 64'(spike_out), 64'(exp_spike(vals, c)));
      check($sformatf("%s c%0d busy/rdy/done", tag, c),
            64'({busy, in_ready, window_done}), 64'({1'b1, 1'b0, (c == 7)}));
      for (int i = 0; i < 16; i++) begin
        if (prev[i] && !spike_out[i]) begin
          fall_cyc[i] = c;
          fallen_q.push_back(int'(vals[i*3 +: 3]));
        end
      end
      prev = spike_out;
    end
    @(negedge clk);
    check($sformatf("%s gap spike", tag), 64'(spike_out), 64'h0000_FFFF);
    check($sformatf("%s gap busy/rdy/done", tag),
          64'({busy, in_ready, window_done}), 64'({1'b1, 1'b0, 1'b0}));
    @(negedge clk);
    check($sformatf("%s idle spike", tag), 64'(spike_out), 64'h0000_FFFF);
    check($sformatf("%s idle busy/rdy/done", tag),
          64'({busy, in_ready, window_done}), 64'({1'b0, 1'b1, 1'b0}));
  endtask

  initial begin
    logic [47:0] v_mod8, v_zero, v_max, v_rand, d;
    int          rand_vals [16];
    int          sorted_q [$];
    int          acc_q [$];
    int          mstate, mcnt;
    logic [47:0] mvals;
    int          waited;

    rand_vals = '{5, 2, 7, 0, 3, 6, 1, 4, 2, 5, 0, 7, 6, 3, 1, 4};
    for (int i = 0; i < 16; i++) begin
      v_mod8[i*3 +: 3] = 3'(i % 8);
      v_rand[i*3 +: 3] = 3'(rand_vals[i]);
    end
    v_zero = '0;
    v_max  = '1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_values = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset spike", 64'(spike_out), 64'h0000_FFFF);
    check("reset busy/rdy/done", 64'({busy, in_ready, window_done}), 64'({1'b0, 1'b1, 1'b0}));
    rst_n = 1'b1;
    @(negedge clk);

    // v_i = i mod 8, with hand-computed masks at a few window cycles.
    run_window("mod8", v_mod8);
    check("mod8 line7 never", 64'(fall_cyc[7]), 64'd8);
    check("mod8 line15 never", 64'(fall_cyc[15]), 64'd8);
    check("mod8 line5 at 5", 64'(fall_cyc[5]), 64'd5);
    check("mod8 line12 at 4", 64'(fall_cyc[12]), 64'd4);
    check("mask c0", 64'(exp_spike(v_mod8, 0)), 64'h0000_FEFE);
    check("mask c3", 64'(exp_spike(v_mod8, 3)), 64'h0000_F0F0);

    // All zero: everything falls in the first window cycle.
    run_window("zero", v_zero);
    for (int i = 0; i < 16; i++) begin
      if (fall_cyc[i] != 0)
        check($sformatf("zero line%0d at 0", i), 64'(fall_cyc[i]), 64'd0);
    end
    check("zero count fallen", 64'(fallen_q.size()), 64'd16);

    // All MAX: no line moves, window_done still pulses (checked per cycle).
    run_window("max", v_max);
    check("max count fallen", 64'(fallen_q.size()), 64'd0);

    // Scrambled vector: fall order must match a software sort.
    run_window("rand", v_rand);
    for (int i = 0; i < 16; i++) begin
      if (rand_vals[i] != 7) sorted_q.push_back(rand_vals[i]);
    end
    sorted_q.sort();
    check("rand fall count", 64'(fallen_q.size()), 64'(sorted_q.size()));
    for (int k = 0; k < sorted_q.size() && k < fallen_q.size(); k++) begin
      check($sformatf("rand order %0d", k), 64'(fallen_q[k]), 64'(sorted_q[k]));
    end
    check("rand line3 at 0", 64'(fall_cyc[3]), 64'd0);
    check("rand line11 never", 64'(fall_cyc[11]), 64'd8);

    // in_valid held high with data changing every cycle.
    mstate = 0;
    mcnt   = 0;
    mvals  = '1;
    in_valid = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("stream k%0d ready", k), 64'(in_ready), 64'(mstate == 0));
      if (mstate == 1)
        check($sformatf("stream k%0d spike", k), 64'(spike_out), 64'(exp_spike(mvals, mcnt)));
      for (int i = 0; i < 16; i++) d[i*3 +: 3] = 3'((i + k) % 8);
      in_values = d;
      if (mstate == 0) begin
        acc_q.push_back(k);
        mvals  = d;
        mstate = 1;
        mcnt   = 0;
      end else if (mstate == 1) begin
        if (mcnt == 7) mstate = 2;
        else mcnt++;
      end else begin
        mstate = 0;
      end
    end
    in_valid = 1'b0;
    check("stream accepts", 64'(acc_q.size()), 64'd4);
    for (int k = 1; k < acc_q.size(); k++)
      check($sformatf("stream spacing %0d", k), 64'(acc_q[k] - acc_q[k-1]), 64'd10);

    // Drain to idle, bounded.
    waited = 0;
    while (!in_ready && waited < 12) begin
      @(negedge clk);
      waited++;
    end
    check("drain ready", 64'(in_ready), 64'd1);

    // Reset pulsed in the middle of a window.
    in_valid  = 1'b1;
    in_values = v_zero;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort pre spike", 64'(spike_out), 64'h0000_0000);
    #2 rst_n = 1'b0;
    #1;
    check("abort async spike", 64'(spike_out), 64'h0000_FFFF);
    check("abort async busy/rdy/done", 64'({busy, in_ready, window_done}), 64'({1'b0, 1'b1, 1'b0}));
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("abort hold %0d done", k), 64'(window_done), 64'd0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      check($sformatf("abort released %0d done/rdy", k),
            64'({window_done, in_ready}), 64'({1'b0, 1'b1}));
    end
    // First edge with in_valid after release is accepted.
    run_window("post_reset", v_mod8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temporal_encoder_16.md
TEMPORAL_ENCODER_16 -- requirements
Module: temporal_encoder_16

Interface
REQ-001 The module SHALL have one parameter: T_W, default 3, the bit width of each time value; the window length is 2^T_W cycles and the legal range is 2..6.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port rst_n SHALL be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-004 The port in_valid SHALL be an input, 1 bit wide: a value vector is offered.
REQ-005 The port in_ready SHALL be an output, 1 bit wide: the encoder accepts a vector this cycle.
REQ-006 The port in_values SHALL be an input, 16*T_W bits wide: the value for line i is bits [i*T_W +: T_W].
REQ-007 The port spike_out SHALL be an output, 16 bits wide: transition-coded lines, idle 1; a 1->0 edge at window cycle t encodes value t.
REQ-008 The port busy SHALL be an output, 1 bit wide: high while a window or the gap cycle is in progress.
REQ-009 The port window_done SHALL be an output, 1 bit wide: a one-cycle pulse in the last cycle of each window.

Function
REQ-010 The encoder SHALL implement an FSM with states IDLE, FIRE and GAP, plus a T_W-bit window counter cnt.
REQ-011 In IDLE the outputs SHALL be: in_ready=1, busy=0, spike_out=16'hFFFF.
REQ-012 A vector SHALL be accepted on a rising edge where in_valid=1 and in_ready=1; the values are latched, cnt is set to 0 and the state moves to FIRE.
REQ-013 in_values and in_valid SHALL be ignored in every cycle in which in_ready=0.
REQ-014 In FIRE the outputs SHALL be in_ready=0 and busy=1, and cnt SHALL increment by 1 each cycle from 0 to MAX=2^T_W-1.
REQ-015 In the FIRE cycle with cnt=c, spike_out[i] SHALL be 0 if and only if v_i <= c and v_i != MAX; the first FIRE cycle is c=0, so a value of 0 falls in the cycle immediately after the accept edge.
REQ-016 v_i=MAX SHALL encode "no spike": that line stays 1 for the whole window.
REQ-017 Within a window each line SHALL make at most one 1->0 transition and SHALL NOT return to 1 before GAP.
REQ-018 Multiple lines with equal values SHALL fall in the same cycle, with no ordering skew between them.
REQ-019 window_done SHALL be 1 exactly in the FIRE cycle where cnt=MAX; cnt SHALL NOT wrap to 0 within FIRE.
REQ-020 The next state after the cnt=MAX cycle SHALL be GAP.
REQ-021 GAP SHALL last exactly one cycle, with spike_out=16'hFFFF (all lines return to 1), in_ready=0, busy=1 and window_done=0; GAP SHALL then move to IDLE.
REQ-022 Minimum spacing between accepts SHALL be 2^T_W+2 cycles: FIRE, then GAP, then at least one IDLE cycle.
REQ-023 spike_out, in_ready, busy and window_done SHALL be driven directly from flops, with no combinational path from any input.

Reset
REQ-024 While rst_n=0, the block SHALL immediately and asynchronously force state=IDLE, cnt=0, latched values=all MAX, spike_out=16'hFFFF, in_ready=1, busy=0, window_done=0.
REQ-025 Reset asserted in FIRE or GAP SHALL abort the window with no window_done pulse, and all lines SHALL go high immediately.
REQ-026 After rst_n deasserts, the first rising edge with in_valid=1 SHALL be accepted.

Verification
REQ-027 Scenario: after reset, T_W=3, accept a vector with v_i = i mod 8 -> line i falls at FIRE cycle i mod 8; lines 7 and 15 never fall; window_done is high in FIRE cycle 7; all lines are 1 in GAP.
REQ-028 Scenario: all v_i=0 -> all 16 lines fall together in the cycle after the accept edge and stay 0 through cnt=7.
REQ-029 Scenario: all v_i=7 -> spike_out stays 16'hFFFF for the whole window, and window_done still pulses once.
REQ-030 Scenario: in_valid held high continuously with changing data -> accepts occur exactly 10 cycles apart, and data presented while in_ready=0 is never used.
REQ-031 Scenario: rst_n pulsed low at FIRE cnt=3 -> spike_out goes to 16'hFFFF asynchronously, window_done does not pulse, and in_ready is 1 right after release.
REQ-032 Scenario: feed the encoder into the 16-input sorter with a random vector -> the sorted output lines fall in ascending value order, matching a software sort.
